cla_subtractor_pipe: RTL and testbench

CLA_SUBTRACTOR_PIPE -- requirements
Module: cla_subtractor_pipe

---
 rtl/cla_subtractor_pipe.sv | 127 ++++++++++++
 tb/tb_cla_subtractor_pipe.sv | 280 ++++++++++++++++++++++++++++
 2 files changed

// File: rtl/cla_subtractor_pipe.sv
// Two-stage pipelined carry-lookahead subtractor: d = a - b - bin mod 2^WIDTH, valid/ready flow control.
// Optional signed-overflow output enabled by defining CLA_SUB_OVF_EN.
module cla_subtractor_pipe #(
    parameter int WIDTH = 7,
    parameter int SPLIT = 4
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic             bin,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] d,
    output logic             bout
`ifdef CLA_SUB_OVF_EN
    ,
    output logic             ovf
`endif
);
    localparam int HI = WIDTH - SPLIT;

    // Stage-1 combinational: propagate/generate of a + ~b, carries of the low slice
    logic [WIDTH-1:0] p;
    logic [WIDTH-1:0] g;
    logic [SPLIT:0]   c_lo;

    generate
        for (genvar gi = 0; gi < WIDTH; gi++) begin : g_pg
            assign p[gi] = a[gi] ^ ~b[gi];
            assign g[gi] = a[gi] & ~b[gi];
        end
    endgenerate

    always_comb begin
        c_lo    = '0;
        c_lo[0] = ~bin;
        for (int i = 0; i < SPLIT; i++) begin
            c_lo[i+1] = g[i] | (p[i] & c_lo[i]);
        end
    end

    // Stage-1 registers
    logic             s1_valid_reg;
    logic [SPLIT-1:0] s1_dlo_reg;
    logic             s1_c_reg;
    logic [HI-1:0]    s1_p_reg;
    logic [HI-1:0]    s1_g_reg;

    // Stage-2 combinational: resolve upper carries from the registered split carry
    logic [HI:0]      c_hi;
    logic [WIDTH-1:0] d_next;
    logic             bout_next;

    always_comb begin
        c_hi    = '0;
        c_hi[0] = s1_c_reg;
        for (int i = 0; i < HI; i++) begin
            c_hi[i+1] = s1_g_reg[i] | (s1_p_reg[i] & c_hi[i]);
        end
        d_next    = {s1_p_reg ^ c_hi[HI-1:0], s1_dlo_reg};
        bout_next = ~c_hi[HI];
    end

    // Stage-2 registers
    logic             s2_valid_reg;
    logic [WIDTH-1:0] d_reg;
    logic             bout_reg;

    logic s2_adv;
    logic s1_adv;

    assign s2_adv    = !s2_valid_reg || out_ready;
    assign s1_adv    = !s1_valid_reg || s2_adv;
    assign in_ready  = s1_adv;
    assign out_valid = s2_valid_reg;
    assign d         = d_reg;
    assign bout      = bout_reg;

    always_ff @(posedge clk) begin
        if (rst) begin
            s1_valid_reg <= 1'b0;
            s1_dlo_reg   <= '0;
            s1_c_reg     <= 1'b0;
            s1_p_reg     <= '0;
            s1_g_reg     <= '0;
            s2_valid_reg <= 1'b0;
            d_reg        <= '0;
            bout_reg     <= 1'b0;
        end else begin
            if (s1_adv) begin
                s1_valid_reg <= in_valid;
            end
            if (s1_adv && in_valid) begin
                s1_dlo_reg <= p[SPLIT-1:0] ^ c_lo[SPLIT-1:0];
                s1_c_reg   <= c_lo[SPLIT];
                s1_p_reg   <= p[WIDTH-1:SPLIT];
                s1_g_reg   <= g[WIDTH-1:SPLIT];
            end
            if (s2_adv) begin
                s2_valid_reg <= s1_valid_reg;
            end
            if (s2_adv && s1_valid_reg) begin
                d_reg    <= d_next;
                bout_reg <= bout_next;
            end
        end
    end

`ifdef CLA_SUB_OVF_EN
    // Signed overflow: carry into the sign bit differs from carry out of it
    logic ovf_reg;

    always_ff @(posedge clk) begin
        if (rst) begin
            ovf_reg <= 1'b0;
        end else if (s2_adv && s1_valid_reg) begin
            ovf_reg <= c_hi[HI] ^ c_hi[HI-1];
        end
    end

    assign ovf = ovf_reg;
`endif

endmodule

// File: tb/tb_cla_subtractor_pipe.sv
// Self-checking bench for cla_subtractor_pipe: directed vector table, backpressure and reset
// sequences, and a randomized run scored against an arithmetic reference model.
module tb_cla_subtractor_pipe;
    localparam int W = 7;

    logic         clk;
    logic         rst;
    logic         in_valid;
    logic         in_ready;
    logic [W-1:0] a;
    logic [W-1:0] b;
    logic         bin;
    logic         out_valid;
    logic         out_ready;
    logic [W-1:0] d;
    logic         bout;
`ifdef CLA_SUB_OVF_EN
    logic         ovf;
`endif

    int checks   = 0;
    int failures = 0;

    cla_subtractor_pipe #(.WIDTH(W), .SPLIT(4)) dut (
        .clk      (clk),
        .rst      (rst),
        .in_valid (in_valid),
        .in_ready (in_ready),
        .a        (a),
        .b        (b),
        .bin      (bin),
        .out_valid(out_valid),
        .out_ready(out_ready),
        .d        (d),
        .bout     (bout)
`ifdef CLA_SUB_OVF_EN
        ,
        .ovf      (ovf)
`endif
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        logic [W-1:0] d;
        logic         bout;
        logic         ovf;
    } res_t;

    typedef struct {
        logic [W-1:0] a;
        logic [W-1:0] b;
        logic         bin;
        logic [W-1:0] exp_d;
        logic         exp_bout;
        logic         exp_ovf;
    } vec_t;

    // Reference: plain integer arithmetic, unsigned for d/bout and signed for ovf
    function automatic res_t ref_sub(input logic [W-1:0] ra, input logic [W-1:0] rb, input logic rbin);
        res_t r;
        int diff;
        int sa;
        int sb;
        int sd;
        diff   = int'(ra) - int'(rb) - int'(rbin);
        r.d    = W'(diff);
        r.bout = (diff < 0);
        sa     = (int'(ra) >= (1 << (W-1))) ? int'(ra) - (1 << W) : int'(ra);
        sb     = (int'(rb) >= (1 << (W-1))) ? int'(rb) - (1 << W) : int'(rb);
        sd     = sa - sb - int'(rbin);
        r.ovf  = (sd > (1 << (W-1)) - 1) || (sd < -(1 << (W-1)));
        return r;
    endfunction

    task automatic chk(input string nm, input int act, input int exp);
        checks++;
        if (act != exp) begin
            failures++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", nm, act, exp);
        end
    endtask

    task automatic chk_result(input string nm, input logic [W-1:0] ed, input logic eb, input logic eo);
        chk({nm, " d"}, int'(d), int'(ed));
        chk({nm, " bout"}, int'(bout), int'(eb));
`ifdef CLA_SUB_OVF_EN
        chk({nm, " ovf"}, int'(ovf), int'(eo));
`else
        if (eo === 1'bx) $display("note: %s has unknown ovf expectation", nm);
`endif
    endtask

    // One operand set with out_ready=1: result must appear exactly 2 cycles after it is driven
    task automatic apply_one(input string nm, input logic [W-1:0] va, input logic [W-1:0] vb,
                             input logic vbin, input logic [W-1:0] ed, input logic eb, input logic eo);
        @(negedge clk);
        in_valid  = 1'b1;
        a         = va;
        b         = vb;
        bin       = vbin;
        out_ready = 1'b1;
        #1;
        chk({nm, " in_ready"}, int'(in_ready), 1);
        @(negedge clk);
        in_valid = 1'b0;
        #1;
        chk({nm, " out_valid@1"}, int'(out_valid), 0);
        @(negedge clk);
        #1;
        chk({nm, " out_valid@2"}, int'(out_valid), 1);
        chk_result(nm, ed, eb, eo);
        $display("txn %s a=%02h b=%02h bin=%0d -> d=%02h bout=%0d", nm, va, vb, vbin, d, bout);
    endtask

    vec_t vecs[10];
    res_t q[$];
    res_t e;
    res_t xr[3];
    logic [W-1:0] xa[3];
    logic [W-1:0] xb[3];
    logic         xbin[3];
    int n_in;
    int n_out;
    logic keep;
    logic prev_stall;

    initial begin
        vecs[0] = '{7'h05, 7'h03, 1'b0, 7'h02, 1'b0, 1'b0};
        vecs[1] = '{7'h00, 7'h01, 1'b0, 7'h7F, 1'b1, 1'b0};
        vecs[2] = '{7'h7F, 7'h7F, 1'b1, 7'h7F, 1'b1, 1'b0};
        vecs[3] = '{7'h3F, 7'h40, 1'b0, 7'h7F, 1'b1, 1'b1};
        vecs[4] = '{7'h40, 7'h01, 1'b0, 7'h3F, 1'b0, 1'b1};
        vecs[5] = '{7'h00, 7'h00, 1'b1, 7'h7F, 1'b1, 1'b0};
        vecs[6] = '{7'h7F, 7'h00, 1'b0, 7'h7F, 1'b0, 1'b0};
        vecs[7] = '{7'h55, 7'h2A, 1'b0, 7'h2B, 1'b0, 1'b1};
        vecs[8] = '{7'h00, 7'h40, 1'b0, 7'h40, 1'b1, 1'b1};
        vecs[9] = '{7'h10, 7'h10, 1'b0, 7'h00, 1'b0, 1'b0};

        rst       = 1'b1;
        in_valid  = 1'b0;
        out_ready = 1'b0;
        a         = '0;
        b         = '0;
        bin       = 1'b0;
        repeat (3) @(negedge clk);
        rst = 1'b0;
        #1;
        chk("reset out_valid", int'(out_valid), 0);
        chk("reset in_ready", int'(in_ready), 1);
        chk_result("reset", 7'h00, 1'b0, 1'b0);

        for (int i = 0; i < 10; i++) begin
            apply_one($sformatf("vec%0d", i), vecs[i].a, vecs[i].b, vecs[i].bin,
                      vecs[i].exp_d, vecs[i].exp_bout, vecs[i].exp_ovf);
        end

        // Backpressure: 3 back-to-back operands, out_ready low for 4 cycles
        xa   = '{7'h11, 7'h22, 7'h05};
        xb   = '{7'h01, 7'h33, 7'h06};
        xbin = '{1'b0, 1'b1, 1'b1};
        for (int i = 0; i < 3; i++) xr[i] = ref_sub(xa[i], xb[i], xbin[i]);
        @(negedge clk);
        out_ready = 1'b0;
        in_valid  = 1'b1;
        a = xa[0]; b = xb[0]; bin = xbin[0];
        #1;
        chk("bp accept0", int'(in_ready), 1);
        @(negedge clk);
        a = xa[1]; b = xb[1]; bin = xbin[1];
        #1;
        chk("bp accept1", int'(in_ready), 1);
        @(negedge clk);
        a = xa[2]; b = xb[2]; bin = xbin[2];
        #1;
        chk("bp held c2", int'(in_ready), 0);
        chk("bp out_valid c2", int'(out_valid), 1);
        @(negedge clk);
        #1;
        chk("bp held c3", int'(in_ready), 0);
        chk("bp hold out_valid", int'(out_valid), 1);
        chk_result("bp hold r0", xr[0].d, xr[0].bout, xr[0].ovf);
        @(negedge clk);
        out_ready = 1'b1;
        #1;
        chk("bp release in_ready", int'(in_ready), 1);
        chk("bp r0 valid", int'(out_valid), 1);
        chk_result("bp r0", xr[0].d, xr[0].bout, xr[0].ovf);
        @(negedge clk);
        in_valid = 1'b0;
        #1;
        chk("bp r1 valid", int'(out_valid), 1);
        chk_result("bp r1", xr[1].d, xr[1].bout, xr[1].ovf);
        @(negedge clk);
        #1;
        chk("bp r2 valid", int'(out_valid), 1);
        chk_result("bp r2", xr[2].d, xr[2].bout, xr[2].ovf);
        @(negedge clk);
        #1;
        chk("bp drained", int'(out_valid), 0);
        $display("txn backpressure sequence done");

        // Reset while two operands are in flight, with in_valid high during reset
        @(negedge clk);
        in_valid = 1'b1; a = 7'h12; b = 7'h05; bin = 1'b0;
        @(negedge clk);
        a = 7'h20; b = 7'h30; bin = 1'b1;
        @(negedge clk);
        rst = 1'b1; a = 7'h7F; b = 7'h00; bin = 1'b0;
        @(negedge clk);
        rst = 1'b0; in_valid = 1'b0;
        #1;
        chk("midrst out_valid", int'(out_valid), 0);
        chk("midrst in_ready", int'(in_ready), 1);
        chk_result("midrst", 7'h00, 1'b0, 1'b0);
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            #1;
            chk($sformatf("midrst quiet%0d", i), int'(out_valid), 0);
        end
        apply_one("postrst", 7'h2A, 7'h15, 1'b0, 7'h15, 1'b0, 1'b0);

        // Randomized traffic against the queue-based scoreboard
        @(negedge clk);
        in_valid = 1'b0;
        #1;
        q.delete();
        n_in       = 0;
        n_out      = 0;
        keep       = 1'b0;
        prev_stall = 1'b0;
        for (int cyc = 0; cyc < 10000; cyc++) begin
            @(negedge clk);
            if (prev_stall) chk("rnd stall hold", int'(out_valid), 1);
            if (!keep) begin
                in_valid = ($urandom_range(0, 3) != 0);
                a        = W'($urandom);
                b        = W'($urandom);
                bin      = 1'($urandom);
            end
            out_ready = ($urandom_range(0, 3) != 0);
            #1;
            if (out_valid && out_ready) begin
                if (q.size() == 0) begin
                    chk("rnd unexpected out", 1, 0);
                end else begin
                    e = q.pop_front();
                    chk_result($sformatf("rnd%0d", n_out), e.d, e.bout, e.ovf);
                    n_out++;
                end
            end
            if (in_valid && in_ready) begin
                q.push_back(ref_sub(a, b, bin));
                n_in++;
            end
            keep       = in_valid && !in_ready;
            prev_stall = out_valid && !out_ready;
        end
        @(negedge clk);
        in_valid  = 1'b0;
        out_ready = 1'b1;
        for (int k = 0; k < 20 && q.size() > 0; k++) begin
            #1;
            if (out_valid) begin
                e = q.pop_front();
                chk($sformatf("drain%0d d", n_out), int'(d), int'(e.d));
                chk($sformatf("drain%0d bout", n_out), int'(bout), int'(e.bout));
                n_out++;
            end
            @(negedge clk);
        end
        chk("rnd count in==out", n_out, n_in);
        chk("rnd queue empty", q.size(), 0);
        $display("txn random run in=%0d out=%0d", n_in, n_out);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
